// File: rtl/video_pkg.sv
// Shared types and defaults for the video memory responder.
// FSM states, requester owners and address helpers.
package video_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DONE
   } state_e;

   typedef enum logic {
      OWN_APPLE,
      OWN_VGC
   } owner_e;

   localparam logic [5:0]  VIDEO_BANK_BASE_DEF = 6'b110000;
   localparam logic [15:0] SHR_BASE_DEF        = 16'h2000;

   // SHR word index to byte offset inside bank E1, 16-bit wrap
   function automatic logic [15:0] vgc_base(
      input logic [12:0] idx,
      input logic [15:0] shr
   );
      return shr + {1'b0, idx, 2'b00};
   endfunction

endpackage

// File: rtl/video_req_slot.sv
// One-entry pending slot for a fetch requester.
// Latches on strobe, flags a strobe that finds the slot occupied.
module video_req_slot #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         rd_i,
   input  logic [W-1:0] addr_i,
   input  logic         take_i,
   output logic         pend_o,
   output logic [W-1:0] addr_o,
   output logic         ovr_o
);

   logic         pend_q;
   logic [W-1:0] addr_q;
   logic         ovr_q;

   // a strobe refills the slot in the same cycle it is dispatched
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pend_q <= 1'b0;
         addr_q <= '0;
         ovr_q  <= 1'b0;
      end else if (rd_i && (!pend_q || take_i)) begin
         pend_q <= 1'b1;
         addr_q <= addr_i;
      end else begin
         if (take_i) pend_q <= 1'b0;
         if (rd_i && pend_q) ovr_q <= 1'b1;
      end
   end

   assign pend_o = pend_q;
   assign addr_o = addr_q;
   assign ovr_o  = ovr_q;

endmodule

// File: rtl/video_mem_responder.sv
// Serves Apple II and VGC 32-bit fetches from a byte-wide video memory.
// VGC has priority; one memory transaction is in flight at a time.
module video_mem_responder
   import video_pkg::*;
#(
   parameter logic [5:0]  VIDEO_BANK_BASE = VIDEO_BANK_BASE_DEF,
   parameter logic [15:0] SHR_BASE        = SHR_BASE_DEF
) (
   input  logic        clk_vid,
   input  logic        reset_n,
   input  logic [15:0] apple_video_addr,
   input  logic        apple_video_bank,
   input  logic        apple_video_rd,
   output logic [31:0] apple_video_data,
   output logic        apple_video_valid,
   input  logic [12:0] vgc_address,
   input  logic        vgc_rd,
   output logic [31:0] vgc_data,
   output logic        vgc_valid,
   output logic [22:0] mem_addr,
   output logic        mem_rd,
   input  logic        mem_ack,
   input  logic [7:0]  mem_data,
   output logic        overrun
);

   logic        a_pend;
   logic        v_pend;
   logic        a_ovr;
   logic        v_ovr;
   logic        a_take;
   logic        v_take;
   logic [16:0] a_slot;
   logic [12:0] v_slot;
   logic [15:0] v_base_d;
   logic [15:0] off_d;

   state_e      state_q;
   owner_e      owner_q;
   logic        bank_q;
   logic [15:0] base_q;
   logic [1:0]  idx_q;
   logic [23:0] word_q;
   logic        mem_rd_q;
   logic [22:0] mem_addr_q;
   logic [31:0] a_data_q;
   logic [31:0] v_data_q;
   logic        a_val_q;
   logic        v_val_q;

   video_req_slot #(.W(17)) u_apple_slot (
      .clk_i  (clk_vid),
      .rst_ni (reset_n),
      .rd_i   (apple_video_rd),
      .addr_i ({apple_video_bank, apple_video_addr}),
      .take_i (a_take),
      .pend_o (a_pend),
      .addr_o (a_slot),
      .ovr_o  (a_ovr)
   );

   video_req_slot #(.W(13)) u_vgc_slot (
      .clk_i  (clk_vid),
      .rst_ni (reset_n),
      .rd_i   (vgc_rd),
      .addr_i (vgc_address),
      .take_i (v_take),
      .pend_o (v_pend),
      .addr_o (v_slot),
      .ovr_o  (v_ovr)
   );

   assign v_take   = (state_q == ST_IDLE) && v_pend;
   assign a_take   = (state_q == ST_IDLE) && a_pend && !v_pend;
   assign v_base_d = vgc_base(v_slot, SHR_BASE);
   assign off_d    = base_q + {14'd0, idx_q} + 16'd1;

   // dispatch, byte-by-byte fetch and completion with registered outputs
   always_ff @(posedge clk_vid or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         owner_q    <= OWN_APPLE;
         bank_q     <= 1'b0;
         base_q     <= '0;
         idx_q      <= '0;
         word_q     <= '0;
         mem_rd_q   <= 1'b0;
         mem_addr_q <= '0;
         a_data_q   <= '0;
         v_data_q   <= '0;
         a_val_q    <= 1'b0;
         v_val_q    <= 1'b0;
      end else begin
         a_val_q <= 1'b0;
         v_val_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (v_pend) begin
                  owner_q    <= OWN_VGC;
                  bank_q     <= 1'b1;
                  base_q     <= v_base_d;
                  idx_q      <= 2'd0;
                  mem_rd_q   <= 1'b1;
                  mem_addr_q <= {VIDEO_BANK_BASE, 1'b1, v_base_d};
                  state_q    <= ST_FETCH;
               end else if (a_pend) begin
                  owner_q    <= OWN_APPLE;
                  bank_q     <= a_slot[16];
                  base_q     <= a_slot[15:0];
                  idx_q      <= 2'd0;
                  mem_rd_q   <= 1'b1;
                  mem_addr_q <= {VIDEO_BANK_BASE, a_slot};
                  state_q    <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               if (mem_ack) begin
                  idx_q <= idx_q + 2'd1;
                  if (idx_q == 2'd3) begin
                     mem_rd_q   <= 1'b0;
                     mem_addr_q <= '0;
                     state_q    <= ST_DONE;
                     if (owner_q == OWN_VGC) begin
                        v_data_q <= {mem_data, word_q};
                        v_val_q  <= 1'b1;
                     end else begin
                        a_data_q <= {mem_data, word_q};
                        a_val_q  <= 1'b1;
                     end
                  end else begin
                     mem_addr_q <= {VIDEO_BANK_BASE, bank_q, off_d};
                     unique case (idx_q)
                        2'd0:    word_q[7:0]   <= mem_data;
                        2'd1:    word_q[15:8]  <= mem_data;
                        default: word_q[23:16] <= mem_data;
                     endcase
                  end
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign apple_video_data  = a_data_q;
   assign apple_video_valid = a_val_q;
   assign vgc_data          = v_data_q;
   assign vgc_valid         = v_val_q;
   assign mem_addr          = mem_addr_q;
   assign mem_rd            = mem_rd_q;
   assign overrun           = a_ovr | v_ovr;

endmodule

// File: tb/tb_video_mem_responder.sv
// Bench for video_mem_responder: byte memory model, scoreboard queues,
// directed steps for priority, wait states, overrun and reset abort.
module tb_video_mem_responder;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] apple_video_addr = '0;
   logic        apple_video_bank = 1'b0;
   logic        apple_video_rd = 1'b0;
   logic [31:0] apple_video_data;
   logic        apple_video_valid;
   logic [12:0] vgc_address = '0;
   logic        vgc_rd = 1'b0;
   logic [31:0] vgc_data;
   logic        vgc_valid;
   logic [22:0] mem_addr;
   logic        mem_rd;
   logic        mem_ack = 1'b0;
   logic [7:0]  mem_data = '0;
   logic        overrun;

   video_mem_responder dut (
      .clk_vid           (clk),
      .reset_n           (reset_n),
      .apple_video_addr  (apple_video_addr),
      .apple_video_bank  (apple_video_bank),
      .apple_video_rd    (apple_video_rd),
      .apple_video_data  (apple_video_data),
      .apple_video_valid (apple_video_valid),
      .vgc_address       (vgc_address),
      .vgc_rd            (vgc_rd),
      .vgc_data          (vgc_data),
      .vgc_valid         (vgc_valid),
      .mem_addr          (mem_addr),
      .mem_rd            (mem_rd),
      .mem_ack           (mem_ack),
      .mem_data          (mem_data),
      .overrun           (overrun)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int wait_n = 0;
   int wcnt = 0;
   int n_av = 0;
   int n_vv = 0;
   int av_cyc = 0;
   int vv_cyc = 0;
   int a_cyc = 0;
   logic        prev_rd = 1'b0;
   logic        prev_ack = 1'b0;
   logic [22:0] last_addr = '0;

   logic [31:0] aq[$];
   logic [31:0] vq[$];
   logic [22:0] addr_log[$];
   bit          order[$];

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] mbyte(input logic [22:0] a);
      case (a)
         23'h600400: return 8'h11;
         23'h600401: return 8'h22;
         23'h600402: return 8'h33;
         23'h600403: return 8'h44;
         default:    return a[7:0] ^ (a[15:8] * 8'd29) ^ {a[22:16], 1'b1};
      endcase
   endfunction

   function automatic logic [31:0] exp_word(input logic bank,
                                            input logic [15:0] base);
      logic [31:0] w;
      logic [15:0] o;
      for (int i = 0; i < 4; i++) begin
         o = base + 16'(i);
         w[i*8 +: 8] = mbyte({6'b110000, bank, o});
      end
      return w;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // memory model with programmable wait states
   always @(negedge clk) begin
      if (mem_rd) begin
         if (prev_rd && !prev_ack)
            chk("addr_stable", 64'(mem_addr), 64'(last_addr));
         if (wcnt == wait_n) begin
            mem_ack = 1'b1;
            mem_data = mbyte(mem_addr);
            addr_log.push_back(mem_addr);
            wcnt = 0;
         end else begin
            mem_ack = 1'b0;
            wcnt++;
         end
      end else begin
         mem_ack = 1'b0;
         wcnt = 0;
      end
      prev_rd = mem_rd;
      prev_ack = mem_ack;
      last_addr = mem_addr;
   end

   // scoreboard on completion pulses
   always @(negedge clk) begin
      if (apple_video_valid) begin
         n_av++;
         av_cyc = cyc;
         order.push_back(1'b0);
         if (aq.size() == 0) chk("apple_extra_valid", 64'd1, 64'd0);
         else chk("apple_data", 64'(apple_video_data), 64'(aq.pop_front()));
      end
      if (vgc_valid) begin
         n_vv++;
         vv_cyc = cyc;
         order.push_back(1'b1);
         if (vq.size() == 0) chk("vgc_extra_valid", 64'd1, 64'd0);
         else chk("vgc_data", 64'(vgc_data), 64'(vq.pop_front()));
      end
   end

   task automatic apple_req(input logic [15:0] a, input logic b,
                            input bit expect_ok);
      @(negedge clk);
      apple_video_addr = a;
      apple_video_bank = b;
      apple_video_rd = 1'b1;
      if (expect_ok) aq.push_back(exp_word(b, a));
      @(negedge clk);
      apple_video_rd = 1'b0;
      a_cyc = cyc;
   endtask

   task automatic vgc_req(input logic [12:0] a);
      logic [15:0] base;
      base = 16'h2000 + 16'(a) * 16'd4;
      @(negedge clk);
      vgc_address = a;
      vgc_rd = 1'b1;
      vq.push_back(exp_word(1'b1, base));
      @(negedge clk);
      vgc_rd = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 400; i++) begin
         if (aq.size() == 0 && vq.size() == 0) break;
         @(negedge clk);
      end
      chk("drain_timeout", 64'(aq.size() + vq.size()), 64'd0);
      repeat (3) @(negedge clk);
   endtask

   int base_av;
   int base_vv;

   initial begin
      // reset state
      repeat (3) @(negedge clk);
      chk("rst_mem_rd", 64'(mem_rd), 64'd0);
      chk("rst_mem_addr", 64'(mem_addr), 64'd0);
      chk("rst_apple_data", 64'(apple_video_data), 64'd0);
      chk("rst_vgc_data", 64'(vgc_data), 64'd0);
      chk("rst_valids", 64'({apple_video_valid, vgc_valid}), 64'd0);
      chk("rst_overrun", 64'(overrun), 64'd0);
      reset_n = 1'b1;

      // basic Apple fetch, known bytes, latency 5
      addr_log.delete();
      apple_req(16'h0400, 1'b0, 1'b1);
      drain();
      chk("a038_lat", 64'(av_cyc - a_cyc), 64'd5);
      chk("a038_nacc", 64'(addr_log.size()), 64'd4);
      for (int i = 0; i < 4; i++)
         chk("a038_addr", 64'(addr_log[i]), 64'(23'h600400 + 23'(i)));
      chk("a038_word", 64'(apple_video_data), 64'h44332211);

      // VGC fetch from SHR
      addr_log.delete();
      base_av = n_av;
      vgc_req(13'h0001);
      drain();
      chk("v039_nvalid", 64'(n_vv), 64'd1);
      chk("v039_no_apple", 64'(n_av - base_av), 64'd0);
      for (int i = 0; i < 4; i++)
         chk("v039_addr", 64'(addr_log[i]), 64'(23'h612004 + 23'(i)));
      chk("v039_apple_hold", 64'(apple_video_data), 64'h44332211);

      // simultaneous strobes: VGC first
      order.delete();
      @(negedge clk);
      apple_video_addr = 16'h1230;
      apple_video_bank = 1'b0;
      apple_video_rd = 1'b1;
      vgc_address = 13'h0abc;
      vgc_rd = 1'b1;
      aq.push_back(exp_word(1'b0, 16'h1230));
      vq.push_back(exp_word(1'b1, 16'h2000 + 16'h0abc * 16'd4));
      @(negedge clk);
      apple_video_rd = 1'b0;
      vgc_rd = 1'b0;
      drain();
      chk("p040_order", 64'({order[0], order[1]}), 64'b10);
      chk("p040_gap", 64'(av_cyc - vv_cyc), 64'd6);

      // wait states: 3 low cycles per byte
      wait_n = 3;
      apple_req(16'h0800, 1'b1, 1'b1);
      drain();
      chk("w041_lat", 64'(av_cyc - a_cyc), 64'd17);

      // overrun: third strobe with slot full is dropped
      base_av = n_av;
      apple_req(16'h0100, 1'b0, 1'b1);
      repeat (2) @(negedge clk);
      apple_req(16'h0200, 1'b0, 1'b1);
      chk("o042_pre", 64'(overrun), 64'd0);
      apple_req(16'h0300, 1'b0, 1'b0);
      chk("o042_set", 64'(overrun), 64'd1);
      drain();
      chk("o042_nvalid", 64'(n_av - base_av), 64'd2);
      chk("o042_sticky", 64'(overrun), 64'd1);
      wait_n = 0;

      // reset during lane 2, then wrapping fetch
      apple_req(16'h1234, 1'b0, 1'b1);
      repeat (3) @(negedge clk);
      chk("r043_lane2", 64'(mem_addr), 64'h601236);
      #2 reset_n = 1'b0;
      #1;
      chk("r043_rd_low", 64'(mem_rd), 64'd0);
      chk("r043_addr0", 64'(mem_addr), 64'd0);
      chk("r043_data0", 64'({apple_video_data, vgc_data}), 64'd0);
      chk("r043_ovr0", 64'(overrun), 64'd0);
      aq.delete();
      addr_log.delete();
      base_av = n_av;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      apple_video_addr = 16'hfffe;
      apple_video_bank = 1'b1;
      apple_video_rd = 1'b1;
      aq.push_back(exp_word(1'b1, 16'hfffe));
      @(negedge clk);
      apple_video_rd = 1'b0;
      a_cyc = cyc;
      drain();
      chk("r043_nvalid", 64'(n_av - base_av), 64'd1);
      chk("r043_lat", 64'(av_cyc - a_cyc), 64'd5);
      chk("r043_nacc", 64'(addr_log.size()), 64'd4);
      chk("r043_a0", 64'(addr_log[0]), 64'h61fffe);
      chk("r043_a1", 64'(addr_log[1]), 64'h61ffff);
      chk("r043_a2", 64'(addr_log[2]), 64'h610000);
      chk("r043_a3", 64'(addr_log[3]), 64'h610001);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
